// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
package pipe_adder_pkg;

   // Opcode encoding on the sub input
   localparam logic ADD = 1'b0;
   localparam logic SUB = 1'b1;

   // Width of the slice resolved by each pipeline stage
   function automatic int unsigned chunk_width(input int unsigned width,
                                               input int unsigned stages);
      return (stages == 0) ? 0 : width / stages;
   endfunction

   // The operand must split into equal, non-empty chunks
   function automatic bit split_ok(input int unsigned width, input int unsigned stages);
      return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/bit_adder.sv
// One-bit full adder cell.
module bit_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/chunk_adder.sv
// CW-bit ripple-carry chain of bit_adder cells; exposes the carry into the MSB for overflow.
module chunk_adder #(
   parameter int unsigned CW = 4
) (
   input  logic [CW-1:0] a,
   input  logic [CW-1:0] b,
   input  logic          ci,
   output logic [CW-1:0] s,
   output logic          co,
   output logic          msb_ci
);

   // Each bit keeps its own carry wires so the chain is not one self-referencing vector
   for (genvar i = 0; i < CW; i++) begin : g_bit
      logic cin;
      logic cout;
      if (i == 0) begin : g_first
         assign cin = ci;
      end else begin : g_next
         assign cin = g_bit[i-1].cout;
      end
      bit_adder u_bit (
         .a  (a[i]),
         .b  (b[i]),
         .ci (cin),
         .s  (s[i]),
         .co (cout)
      );
   end

   assign co     = g_bit[CW-1].cout;
   assign msb_ci = g_bit[CW-1].cin;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder/subtractor with valid/ready on both sides.
// Stage k resolves chunk k; the carry and the remaining operand chunks travel with the data.
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             c1,
   output logic             ovf
);

   localparam int unsigned CW = chunk_width(WIDTH, STAGES);

   if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
      $error("pipe_adder: WIDTH must be a non-zero multiple of STAGES");
   end

   // Subtraction is a + ~b + !ci, so the operand is inverted once at the input
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;
   assign b_eff   = (sub == SUB) ? ~b : b;
   assign cin_eff = (sub == ADD) ? ci : ~ci;

   logic [STAGES-1:0] v_q, v_d;
   logic [STAGES:0]   rdy;
   logic [WIDTH-1:0]  a_q   [STAGES];
   logic [WIDTH-1:0]  a_d   [STAGES];
   logic [WIDTH-1:0]  b_q   [STAGES];
   logic [WIDTH-1:0]  b_d   [STAGES];
   logic [WIDTH-1:0]  res_q [STAGES];
   logic [WIDTH-1:0]  res_d [STAGES];
   logic [STAGES-1:0] c_q, c_d;
   logic              ovf_q, ovf_d;

   logic [CW-1:0] ca_s   [STAGES];
   logic          ca_co  [STAGES];
   logic          ca_msb [STAGES];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [CW-1:0] op_a;
      logic [CW-1:0] op_b;
      logic          op_c;
      if (k == 0) begin : g_head
         assign op_a = a[CW-1:0];
         assign op_b = b_eff[CW-1:0];
         assign op_c = cin_eff;
      end else begin : g_body
         assign op_a = a_q[k-1][k*CW +: CW];
         assign op_b = b_q[k-1][k*CW +: CW];
         assign op_c = c_q[k-1];
      end
      chunk_adder #(.CW(CW)) u_chunk (
         .a      (op_a),
         .b      (op_b),
         .ci     (op_c),
         .s      (ca_s[k]),
         .co     (ca_co[k]),
         .msb_ci (ca_msb[k])
      );
   end

   // Ready chain from the consumer back to the input; an empty stage always accepts
   always_comb begin
      rdy         = '0;
      rdy[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         rdy[k] = !v_q[k] || rdy[k+1];
      end
   end

   // Advance each stage that may load; data only moves alongside a valid entry
   always_comb begin
      v_d   = v_q;
      c_d   = c_q;
      ovf_d = ovf_q;
      a_d   = a_q;
      b_d   = b_q;
      res_d = res_q;
      if (rdy[0]) begin
         v_d[0] = in_valid;
         if (in_valid) begin
            a_d[0]            = a;
            b_d[0]            = b_eff;
            res_d[0]          = '0;
            res_d[0][CW-1:0]  = ca_s[0];
            c_d[0]            = ca_co[0];
            if (STAGES == 1) begin
               ovf_d = ca_msb[0] ^ ca_co[0];
            end
         end
      end
      for (int k = 1; k < STAGES; k++) begin
         if (rdy[k]) begin
            v_d[k] = v_q[k-1];
            if (v_q[k-1]) begin
               a_d[k]                = a_q[k-1];
               b_d[k]                = b_q[k-1];
               res_d[k]              = res_q[k-1];
               res_d[k][k*CW +: CW]  = ca_s[k];
               c_d[k]                = ca_co[k];
               if (k == STAGES - 1) begin
                  ovf_d = ca_msb[k] ^ ca_co[k];
               end
            end
         end
      end
   end

   // Pipeline registers; reset clears valids and the visible result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q   <= '0;
         c_q   <= '0;
         ovf_q <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            res_q[k] <= '0;
         end
      end else begin
         v_q   <= v_d;
         c_q   <= c_d;
         ovf_q <= ovf_d;
         a_q   <= a_d;
         b_q   <= b_d;
         res_q <= res_d;
      end
   end

   assign in_ready  = rdy[0];
   assign out_valid = v_q[STAGES-1];
   assign s         = res_q[STAGES-1];
   assign c1        = c_q[STAGES-1];
   assign ovf       = ovf_q;

endmodule
